// File: rtl/magic_trigger_if.sv
// Board-side signal bundle for the Magic trigger front-end.
// The master modport is the board/keyboard/frame side; slave is the trigger block.
interface magic_trigger_if;
  logic button_n;
  logic ps2_magic;
  logic ps2_reset;
  logic magic_reboot;
  logic n_int;
  logic n_int_next;
  logic magic_button;
  logic n_rst_sys;

  modport master (
    output button_n, ps2_magic, ps2_reset, magic_reboot, n_int, n_int_next,
    input  magic_button, n_rst_sys
  );

  modport slave (
    input  button_n, ps2_magic, ps2_reset, magic_reboot, n_int, n_int_next,
    output magic_button, n_rst_sys
  );
endinterface

// File: rtl/magic_trigger.sv
// Magic button front-end: sync, debounce, short/long press split, frame-aligned
// request holding and a stretched system reset pulse (one pulse on every boot).
module magic_trigger #(
  parameter int PRESCALE     = 28000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int LONG_MS      = 2000,
  parameter int RESET_CYCLES = 1400000
) (
  input  logic          clk28,
  input  logic          rst_n,
  magic_trigger_if.slave bus
);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {P_IDLE, P_PRESSED, P_LONG} press_t;
  typedef enum logic {S_RUN, S_HOLD} seq_t;

  logic [1:0]    r_sync;
  logic          w_btn;
  logic [PW-1:0] r_pre;
  logic          w_tick;
  logic [DW-1:0] r_stab;
  logic          r_deb;
  press_t        r_pst, w_pnxt;
  logic [HW-1:0] r_hold;
  logic          w_short, w_long;
  logic          r_reboot_prev, r_reboot_edge;
  logic          w_trig;
  logic          w_int_edge;
  logic          r_pending;
  seq_t          r_sst, w_snxt;
  logic [RW-1:0] r_rcnt;
  logic          r_n_rst;

  // Synchroniser stage: idle level of the raw button is high.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.button_n};
  end
  assign w_btn = ~r_sync[1];

  assign w_tick = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_stab <= '0;
      r_deb  <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_btn == r_deb) begin
        r_stab <= '0;
      end else if (w_tick) begin
        if (r_stab == DW'(DEBOUNCE_MS - 1)) begin
          r_deb  <= w_btn;
          r_stab <= '0;
        end else begin
          r_stab <= r_stab + DW'(1);
        end
      end
    end
  end

  // Press classification stage.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_pst  <= P_IDLE;
      r_hold <= '0;
    end else begin
      r_pst <= w_pnxt;
      if (r_pst != P_PRESSED) r_hold <= '0;
      else if (w_tick)        r_hold <= r_hold + HW'(1);
    end
  end

  always_comb begin
    w_pnxt  = r_pst;
    w_short = 1'b0;
    w_long  = 1'b0;
    case (r_pst)
      P_IDLE:    if (r_deb) w_pnxt = P_PRESSED;
      P_PRESSED: begin
        if (!r_deb) begin
          w_short = 1'b1;
          w_pnxt  = P_IDLE;
        end else if (w_tick && r_hold == HW'(LONG_MS - 1)) begin
          w_long = 1'b1;
          w_pnxt = P_LONG;
        end
      end
      P_LONG:    if (!r_deb) w_pnxt = P_IDLE;
      default:   w_pnxt = P_IDLE;
    endcase
  end

  // Request and trigger stage: a set always beats a clear.
  assign w_trig     = w_long | bus.ps2_reset | r_reboot_edge;
  assign w_int_edge = r_pending & bus.n_int & ~bus.n_int_next;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_reboot_prev <= 1'b0;
      r_reboot_edge <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_reboot_prev <= bus.magic_reboot;
      r_reboot_edge <= bus.magic_reboot & ~r_reboot_prev;
      if (bus.ps2_magic | w_short)  r_pending <= 1'b1;
      else if (w_int_edge | w_trig) r_pending <= 1'b0;
    end
  end

  // Reset sequencer stage: boots in HOLD so every power-up gets a full pulse.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_sst   <= S_HOLD;
      r_rcnt  <= '0;
      r_n_rst <= 1'b0;
    end else begin
      r_sst   <= w_snxt;
      r_rcnt  <= (r_sst == S_HOLD && w_snxt == S_HOLD) ? r_rcnt + RW'(1) : '0;
      r_n_rst <= (w_snxt == S_RUN);
    end
  end

  always_comb begin
    w_snxt = r_sst;
    case (r_sst)
      S_RUN:   if (w_trig) w_snxt = S_HOLD;
      S_HOLD:  if (r_rcnt == RW'(RESET_CYCLES - 1)) w_snxt = S_RUN;
      default: w_snxt = S_HOLD;
    endcase
  end

  assign bus.magic_button = r_pending;
  assign bus.n_rst_sys    = r_n_rst;
endmodule

// File: doc/magic_trigger.md
# magic_trigger

Front-end for the Magic subsystem: turns the raw Magic push-button, keyboard hotkey pulses and the configuration reboot request into the clean `magic_button` level consumed by the Magic/NMI controller and a timed system reset. It sits between the board inputs and the PS/2 decoder on one side, and the Magic controller and CPU/system reset net on the other. It handles synchronisation, debounce, short/long-press classification, request holding until the frame interrupt, and reset pulse stretching.

## Interface
- `PRESCALE`, default 28000: clk28 cycles per debounce tick (1 ms).
- `DEBOUNCE_MS`, default 10: consecutive ticks a changed input must stay stable before it is accepted.
- `LONG_MS`, default 2000: hold time in ticks that reclassifies a press as a reset request.
- `RESET_CYCLES`, default 1400000: `n_rst_sys` low time in clk28 cycles (50 ms).

Ports:
- `clk28`  in  1  system clock, 28 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `button_n`  in  1  raw Magic button, asynchronous, active-low.
- `ps2_magic`  in  1  one-cycle pulse from the keyboard hotkey decoder (Magic).
- `ps2_reset`  in  1  one-cycle pulse from the keyboard hotkey decoder (reset).
- `magic_reboot`  in  1  reboot request level from the Magic config registers.
- `n_int`  in  1  current frame interrupt, active-low.
- `n_int_next`  in  1  frame interrupt value for the next cycle.
- `magic_button`  out  1  Magic request level to the Magic controller.
- `n_rst_sys`  out  1  system/CPU reset, active-low.

## Operation
- Synchroniser: `button_n` passes through 2 flops (reset value 1). The FSM sees `btn = ~sync` as pressed-high.
- Tick: a free-running prescaler emits a 1-cycle `tick` every `PRESCALE` cycles.
- Debounce:
  - `deb` has reset value 0.
  - A stability counter clears whenever `btn == deb`.
  - On each tick while `btn != deb`, the counter increments.
  - When the counter reaches `DEBOUNCE_MS`, `deb <= btn` and the counter clears.
  - Effective latency is between (DEBOUNCE_MS−1)·PRESCALE and DEBOUNCE_MS·PRESCALE cycles.
- Press FSM, states IDLE, PRESSED, LONG:
  - IDLE: on `deb` rising, clear the hold counter and go to PRESSED.
  - PRESSED: the hold counter increments per tick.
    - `deb` falling with hold < `LONG_MS`: short press, set `pending`, go to IDLE.
    - Hold reaches `LONG_MS`: fire a reset trigger, go to LONG.
  - LONG: wait for `deb` falling, then go to IDLE. No Magic request is raised.
- Pending request:
  - Set by a short press or a `ps2_magic` pulse.
  - `magic_button = pending`.
  - Cleared on the cycle after a cycle where `pending && n_int && !n_int_next`, so the consumer samples it exactly once, at that edge.
  - Cleared when a reset trigger fires.
  - A set and a clear in the same cycle: the set wins.
- Reset sequencer, states RUN and HOLD:
  - Triggers: long press, `ps2_reset` pulse, or a `magic_reboot` rising edge. The previous-value register has reset value 0.
  - RUN + trigger: go to HOLD and load the cycle counter.
  - HOLD: `n_rst_sys` = 0. When `RESET_CYCLES` cycles have elapsed, return to RUN.
  - Triggers during HOLD are ignored and do not extend the pulse.
  - `magic_reboot` staying high does not retrigger. A new 0→1 edge is required.
- Power-up: after `rst_n` deasserts, the sequencer starts in HOLD with a full count, so every boot gets one `RESET_CYCLES` pulse.
- The FSM, debounce and `pending` are not reset by `n_rst_sys`; only `rst_n` resets them.

## Timing
- Reset values while `rst_n` is low:
  - `magic_button` = 0.
  - `n_rst_sys` = 0, held for `RESET_CYCLES` cycles after `rst_n` deasserts.
  - All counters 0.
  - FSM in IDLE; sequencer in HOLD.
- `ps2_magic` → `magic_button` = 1 on the next cycle.
- Long-press reset: `n_rst_sys` falls 1 cycle after the tick on which hold reaches `LONG_MS`.
- `magic_reboot` edge → `n_rst_sys` falls 2 cycles later (edge register plus sequencer register).
- `n_rst_sys` low width is exactly `RESET_CYCLES` cycles.
- All outputs are registered; no combinational input-to-output path.

## Test plan
Bench parameters: PRESCALE=4, DEBOUNCE_MS=2, LONG_MS=10, RESET_CYCLES=16.

- Power-up: release `rst_n` → `n_rst_sys` low for exactly 16 cycles, then 1; `magic_button` stays 0.
- Bounce rejection: toggle `button_n` with 3-cycle pulses for 40 cycles → `deb` never changes, `magic_button` stays 0.
- Short press: hold `button_n` = 0 for 20 cycles, then release → `magic_button` = 1 after the release is debounced. Stays 1 until a cycle with `n_int=1`, `n_int_next=0`; clears the next cycle, with exactly one sampled cycle.
- Long press: hold `button_n` = 0 for 60 cycles → one 16-cycle `n_rst_sys` pulse, `magic_button` stays 0, and no request on release.
- Reboot: `magic_reboot` 0→1, held high for 100 cycles → exactly one 16-cycle pulse. A `ps2_reset` during HOLD does not lengthen it.
- Simultaneous events: `ps2_magic` on the same cycle as the `n_int` falling edge with `pending` already 1 → `magic_button` stays 1.
